// File: rtl/bip_pkg.sv
// Shared encodings for the BIP core: opcodes and datapath control-field values.
package bip_pkg;

  typedef enum logic [4:0] {
    HLT  = 5'd0,
    STO  = 5'd1,
    LD   = 5'd2,
    LDI  = 5'd3,
    ADD  = 5'd4,
    ADDI = 5'd5,
    SUB  = 5'd6,
    SUBI = 5'd7
  } opcode_e;

  localparam logic [1:0] SEL_A_MEM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;
  localparam logic [1:0] SEL_A_RSV = 2'd3;

  localparam logic SEL_B_MEM = 1'b0;
  localparam logic SEL_B_IMM = 1'b1;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/datapath_data_memory.sv
// BIP data memory: synchronous write, combinational read gated by the read strobe.
module data_memory #(
  parameter int NB_DATA   = 16,
  parameter int NB_ADDR   = 11,
  parameter int RAM_DEPTH = 2**NB_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic               re,
  input  logic [NB_ADDR-1:0] addr,
  input  logic [NB_DATA-1:0] wdata,
  output logic [NB_DATA-1:0] rdata
);

  logic [NB_DATA-1:0] mem [RAM_DEPTH];

  // Contents survive reset; reset only blocks a write landing on the same edge.
  always_ff @(posedge clk) begin
    if (we && !rst) mem[addr] <= wdata;
  end

  assign rdata = re ? mem[addr] : '0;

endmodule

// File: rtl/datapath.sv
// BIP execution datapath: accumulator, add/sub ALU, operand sign extension and data memory.
module datapath
  import bip_pkg::*;
#(
  parameter int NB_DATA          = 16,
  parameter int NB_OPERAND       = 11,
  parameter int NB_DECODER_SEL_A = 2,
  parameter int NB_DECODER       = 1,
  parameter int RAM_DEPTH        = 2**NB_OPERAND
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NB_OPERAND-1:0]       i_operand,
  input  logic [NB_DECODER_SEL_A-1:0] i_selA,
  input  logic [NB_DECODER-1:0]       i_selB,
  input  logic [NB_DECODER-1:0]       i_wrAcc,
  input  logic [NB_DECODER-1:0]       i_op,
  input  logic [NB_DECODER-1:0]       i_wrRam,
  input  logic [NB_DECODER-1:0]       i_rdRam,
  output logic [NB_DATA-1:0]          o_acc,
  output logic [NB_DATA-1:0]          o_mem_data
);

  localparam int NB_ADDR = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  logic [NB_DATA-1:0] acc;
  logic [NB_DATA-1:0] imm;
  logic [NB_DATA-1:0] mem_rd;
  logic [NB_DATA-1:0] alu_b;
  logic [NB_DATA-1:0] alu_res;
  logic [NB_DATA-1:0] acc_mux;
  logic               acc_we;

  assign imm = {{(NB_DATA-NB_OPERAND){i_operand[NB_OPERAND-1]}}, i_operand};

  // Low address bits only, so out-of-range addresses wrap onto the array.
  data_memory #(
    .NB_DATA  (NB_DATA),
    .NB_ADDR  (NB_ADDR),
    .RAM_DEPTH(RAM_DEPTH)
  ) u_data_memory (
    .clk  (i_clk),
    .rst  (i_rst),
    .we   (i_wrRam[0]),
    .re   (i_rdRam[0]),
    .addr (i_operand[NB_ADDR-1:0]),
    .wdata(acc),
    .rdata(mem_rd)
  );

  always_comb begin
    alu_b   = (i_selB[0] == SEL_B_IMM) ? imm : mem_rd;
    alu_res = (i_op[0] == OP_SUB) ? (acc - alu_b) : (acc + alu_b);
    case (i_selA)
      SEL_A_MEM: acc_mux = mem_rd;
      SEL_A_IMM: acc_mux = imm;
      SEL_A_ALU: acc_mux = alu_res;
      default:   acc_mux = acc;
    endcase
  end

  // The reserved select never writes, even with the write strobe up.
  assign acc_we = i_wrAcc[0] && (i_selA != SEL_A_RSV);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       acc <= '0;
    else if (acc_we) acc <= acc_mux;
  end

  assign o_acc      = acc;
  assign o_mem_data = mem_rd;

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for the BIP datapath: directed instruction sequences plus random control words.
module tb_datapath;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [10:0] i_operand = '0;
  logic [1:0]  i_selA = '0;
  logic [0:0]  i_selB = '0, i_wrAcc = '0, i_op = '0, i_wrRam = '0, i_rdRam = '0;
  logic [15:0] o_acc, o_mem_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_acc;
  logic [15:0] m_mem [2048];
  bit          m_kn  [2048];
  logic [15:0] seen_mem;

  datapath dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_operand(i_operand), .i_selA(i_selA),
    .i_selB(i_selB), .i_wrAcc(i_wrAcc), .i_op(i_op), .i_wrRam(i_wrRam),
    .i_rdRam(i_rdRam), .o_acc(o_acc), .o_mem_data(o_mem_data)
  );

  always #5 i_clk = ~i_clk;

  // One instruction cycle: drive, sample the read bus, advance the model, clock.
  task automatic cyc(input logic [1:0] sa, input logic sb, wa, op, wr, rd, input logic [10:0] opd);
    logic [15:0] imm, rdv, b, nxt;
    i_selA = sa; i_selB = sb; i_wrAcc = wa; i_op = op; i_wrRam = wr; i_rdRam = rd; i_operand = opd;
    #1 seen_mem = o_mem_data;
    imm = {{5{opd[10]}}, opd};
    rdv = rd ? m_mem[opd] : 16'h0;
    b   = sb ? imm : rdv;
    case (sa)
      2'd0:    nxt = rdv;
      2'd1:    nxt = imm;
      2'd2:    nxt = op ? m_acc - b : m_acc + b;
      default: nxt = m_acc;
    endcase
    if (wr) begin m_mem[opd] = m_acc; m_kn[opd] = 1'b1; end
    if (wa) m_acc = nxt;
    @(posedge i_clk); #1;
  endtask

  task automatic idle();                    cyc(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h0); endtask
  task automatic ldi (input logic [10:0] x); cyc(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, x); endtask
  task automatic sto (input logic [10:0] a); cyc(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, a); endtask
  task automatic ld  (input logic [10:0] a); cyc(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, a); endtask
  task automatic add (input logic [10:0] a); cyc(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, a); endtask
  task automatic sub (input logic [10:0] a); cyc(2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, a); endtask
  task automatic addi(input logic [10:0] x); cyc(2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, x); endtask
  task automatic subi(input logic [10:0] x); cyc(2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, x); endtask

  task automatic test_reset();
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    checks++; if (o_acc !== 16'h0) begin errors++; $display("FAIL reset_acc got %h want 0000", o_acc); end
    i_rst = 1'b0; m_acc = 16'h0;
    ldi(11'h055);
    checks++; if (o_acc !== 16'h0055) begin errors++; $display("FAIL ldi_55 got %h want 0055", o_acc); end
    sto(11'h020);
    ldi(11'h066);
    // LDI + STO issued while reset rises mid-cycle: both writes must be cancelled.
    i_selA = 2'd1; i_wrAcc = 1'b1; i_wrRam = 1'b1; i_rdRam = 1'b0; i_operand = 11'h077;
    #2 i_rst = 1'b1;
    #1 checks++; if (o_acc !== 16'h0) begin errors++; $display("FAIL reset_async got %h want 0000", o_acc); end
    @(posedge i_clk); #1;
    checks++; if (o_acc !== 16'h0) begin errors++; $display("FAIL reset_edge got %h want 0000", o_acc); end
    i_rst = 1'b0; m_acc = 16'h0;
    ld(11'h020);
    checks++; if (seen_mem !== 16'h0055) begin errors++; $display("FAIL reset_ram_kept got %h want 0055", seen_mem); end
    ldi(11'h7FF);
    checks++; if (o_acc !== 16'hFFFF) begin errors++; $display("FAIL ldi_sext got %h want ffff", o_acc); end
  endtask

  task automatic test_sto_ld();
    ldi(11'd5); sto(11'h010); ldi(11'd0);
    checks++; if (o_acc !== 16'h0) begin errors++; $display("FAIL ldi_0 got %h want 0000", o_acc); end
    ld(11'h010);
    checks++; if (seen_mem !== 16'h0005) begin errors++; $display("FAIL ld_bus got %h want 0005", seen_mem); end
    checks++; if (o_acc !== 16'h0005) begin errors++; $display("FAIL ld_acc got %h want 0005", o_acc); end
  endtask

  task automatic test_alu_mem();
    ldi(11'd7); sto(11'd3); ldi(11'd10);
    add(11'd3);
    checks++; if (o_acc !== 16'd17) begin errors++; $display("FAIL add_mem got %h want 0011", o_acc); end
    sub(11'd3);
    checks++; if (o_acc !== 16'd10) begin errors++; $display("FAIL sub_mem got %h want 000a", o_acc); end
    subi(11'h7F6);
    checks++; if (o_acc !== 16'h0014) begin errors++; $display("FAIL subi_neg got %h want 0014", o_acc); end
  endtask

  task automatic test_wrap();
    ldi(11'd1);
    for (int i = 0; i < 15; i++) begin sto(11'h100); add(11'h100); end
    subi(11'd1);
    checks++; if (o_acc !== 16'h7FFF) begin errors++; $display("FAIL build_7fff got %h want 7fff", o_acc); end
    addi(11'd1);
    checks++; if (o_acc !== 16'h8000) begin errors++; $display("FAIL wrap_add got %h want 8000", o_acc); end
    ldi(11'd0); subi(11'd1);
    checks++; if (o_acc !== 16'hFFFF) begin errors++; $display("FAIL wrap_sub got %h want ffff", o_acc); end
  endtask

  task automatic test_simultaneous();
    ldi(11'd9);
    cyc(2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd4);
    checks++; if (o_acc !== 16'd4) begin errors++; $display("FAIL simul_acc got %h want 0004", o_acc); end
    // Read and write the same word: bus shows the old content this cycle.
    cyc(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 11'd4);
    checks++; if (seen_mem !== 16'd9) begin errors++; $display("FAIL simul_ram got %h want 0009", seen_mem); end
    ld(11'd4);
    checks++; if (o_acc !== 16'd4) begin errors++; $display("FAIL rw_new got %h want 0004", o_acc); end
  endtask

  task automatic test_hold_reserved();
    ldi(11'h123);
    for (int i = 0; i < 10; i++) begin
      idle();
      checks++; if (o_acc !== 16'h0123) begin errors++; $display("FAIL hold_acc[%0d] got %h want 0123", i, o_acc); end
    end
    cyc(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'h010);
    checks++; if (seen_mem !== 16'h0005) begin errors++; $display("FAIL hold_mem got %h want 0005", seen_mem); end
    cyc(2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 11'h010);
    checks++; if (o_acc !== 16'h0123) begin errors++; $display("FAIL rsv_sel got %h want 0123", o_acc); end
    cyc(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h010);
    checks++; if (seen_mem !== 16'h0) begin errors++; $display("FAIL rd_gate got %h want 0000", seen_mem); end
  endtask

  task automatic test_random();
    logic [1:0] sa; logic sb, wa, op, wr, rd; logic [10:0] opd; logic [15:0] exp_bus;
    for (int a = 0; a < 16; a++) begin ldi(11'($urandom)); sto(11'(a)); end
    for (int n = 0; n < 400; n++) begin
      sa = 2'($urandom); sb = 1'($urandom); wa = 1'($urandom); op = 1'($urandom);
      wr = ($urandom_range(0, 3) == 0); rd = 1'($urandom);
      opd = $urandom_range(0, 1) ? 11'($urandom_range(0, 15)) : 11'($urandom);
      if (!m_kn[opd]) rd = 1'b0;
      exp_bus = rd ? m_mem[opd] : 16'h0;
      cyc(sa, sb, wa, op, wr, rd, opd);
      checks++; if (seen_mem !== exp_bus) begin errors++; $display("FAIL rnd_bus[%0d] got %h want %h", n, seen_mem, exp_bus); end
      checks++; if (o_acc !== m_acc) begin errors++; $display("FAIL rnd_acc[%0d] got %h want %h", n, o_acc, m_acc); end
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin m_mem[i] = 16'h0; m_kn[i] = 1'b0; end
    m_acc = 16'h0;
    test_reset();
    test_sto_ld();
    test_alu_mem();
    test_wrap();
    test_simultaneous();
    test_hold_reserved();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
